// File: rtl/mips_cpu_dmem_wait.sv
// Word-addressed data RAM for the CPU data port, with byte enables and a
// programmable-length waitrequest stall on every access.
module mips_cpu_dmem_wait #(
    parameter string       RAM_INIT_FILE = "",
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned LATENCY       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic        fault
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mips_cpu_dmem_wait: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StCount, StAck} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      be_q;
    logic            write_q;
    logic [31:0]     rdata_q;
    logic            fault_q;
    logic [31:0]     mem [Depth];

    logic                  req;
    logic                  capture;
    logic                  enter_ack;
    logic                  commit;
    logic [31:0]           acc_addr;
    logic                  acc_write;
    logic                  acc_oor;
    logic [ADDR_WIDTH-1:0] acc_idx;

    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = '0;
    end

    assign req = data_read | data_write;

    // In IDLE the access is being captured this edge, so decode the live inputs.
    always_comb begin
        acc_addr  = (state_q == StIdle) ? data_address : addr_q;
        acc_write = (state_q == StIdle) ? data_write : write_q;
        acc_oor   = (acc_addr >> (ADDR_WIDTH + 2)) != 32'd0;
        acc_idx   = acc_addr[ADDR_WIDTH+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StAck;
                    end else begin
                        state_d = StCount;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            StCount: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_ack = (state_d == StAck) && (state_q != StAck);
    assign commit    = (state_q == StAck) && write_q && !acc_oor && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_ack && !acc_write) rdata_q <= acc_oor ? 32'd0 : mem[acc_idx];
            if (enter_ack && acc_oor) fault_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= data_address;
            write_q <= data_write;
            be_q    <= data_byteenable;
            wdata_q <= data_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[acc_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign data_readdata    = rdata_q;
    assign data_waitrequest = req & (state_q != StAck);
    assign fault            = fault_q;

endmodule

// File: tb/tb_mips_cpu_dmem_wait.sv
// Directed bench for mips_cpu_dmem_wait: three instances with LATENCY 2, 1 and 4.
module tb_mips_cpu_dmem_wait;

    logic        clk;
    logic        rst     [3];
    logic [31:0] addr    [3];
    logic        wr      [3];
    logic        rd      [3];
    logic [3:0]  be      [3];
    logic [31:0] wdata   [3];
    logic [31:0] rdata   [3];
    logic        waitreq [3];
    logic        fault   [3];

    int n_tests;
    int n_fail;

    mips_cpu_dmem_wait #(.LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst[0]), .data_address(addr[0]), .data_write(wr[0]),
        .data_read(rd[0]), .data_byteenable(be[0]), .data_writedata(wdata[0]),
        .data_readdata(rdata[0]), .data_waitrequest(waitreq[0]), .fault(fault[0])
    );

    mips_cpu_dmem_wait #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[1]), .data_address(addr[1]), .data_write(wr[1]),
        .data_read(rd[1]), .data_byteenable(be[1]), .data_writedata(wdata[1]),
        .data_readdata(rdata[1]), .data_waitrequest(waitreq[1]), .fault(fault[1])
    );

    mips_cpu_dmem_wait #(.LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst[2]), .data_address(addr[2]), .data_write(wr[2]),
        .data_read(rd[2]), .data_byteenable(be[2]), .data_writedata(wdata[2]),
        .data_readdata(rdata[2]), .data_waitrequest(waitreq[2]), .fault(fault[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request, counts stall cycles until waitrequest drops, returns
    // readdata seen in the ACK cycle. Leaves inputs held just after the ACK edge.
    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rv);
        rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        stalls = 0;
        rv = 32'hx;
        forever begin
            @(negedge clk);
            if (!waitreq[d]) begin
                rv = rdata[d];
                break;
            end
            stalls++;
            if (stalls > 20) begin
                stalls = -1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdata[d] !== 32'd0) begin
                n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]);
            end
            n_tests++;
            if (fault[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_fault[%0d]: got %b expected 0", d, fault[d]);
            end
            n_tests++;
            if (waitreq[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_wait[%0d]: got %b expected 0", d, waitreq[d]);
            end
        end
    endtask

    task automatic test_read_lat2();
        int st; logic [31:0] v;
        access(0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF, st, v); idle(0);
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL lat2_write_stall: got %0d expected 2", st); end
        access(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, st, v); idle(0);
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL lat2_read_stall: got %0d expected 2", st); end
        n_tests++;
        if (v !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lat2_read_data: got %h expected deadbeef", v);
        end
        n_tests++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lat2_read_hold: got %h expected deadbeef", rdata[0]);
        end
    endtask

    task automatic test_partial_write();
        int st; logic [31:0] v;
        access(0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hAABBCCDD, st, v); idle(0);
        access(0, 1'b0, 1'b1, 32'h8, 4'b0101, 32'h11223344, st, v); idle(0);
        n_tests++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_keeps_rdata: got %h expected deadbeef", rdata[0]);
        end
        access(0, 1'b0, 1'b1, 32'hB, 4'b0000, 32'hFFFFFFFF, st, v); idle(0);
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL be0_stall: got %0d expected 2", st); end
        access(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0, st, v); idle(0);
        n_tests++;
        if (v !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL partial_write: got %h expected aa22cc44", v);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2; logic [31:0] v;
        access(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'h12345678, st1, v);
        access(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, st2, v);
        idle(1);
        n_tests++;
        if (st1 !== 1) begin n_fail++; $display("FAIL b2b_write_stall: got %0d expected 1", st1); end
        n_tests++;
        if (st2 !== 1) begin n_fail++; $display("FAIL b2b_read_stall: got %0d expected 1", st2); end
        n_tests++;
        if (v !== 32'h12345678) begin
            n_fail++; $display("FAIL b2b_read_data: got %h expected 12345678", v);
        end
    endtask

    task automatic test_out_of_range();
        int st; logic [31:0] v;
        access(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, st, v); idle(1);
        access(1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0000FFFF, st, v); idle(1);
        n_tests++;
        if (st !== 1) begin n_fail++; $display("FAIL oor_write_stall: got %0d expected 1", st); end
        n_tests++;
        if (fault[1] !== 1'b1) begin
            n_fail++; $display("FAIL oor_fault: got %b expected 1", fault[1]);
        end
        access(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, st, v); idle(1);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 0", v); end
        access(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, st, v); idle(1);
        access(1, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, st, v); idle(1);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL oor_read_zero: got %h expected 0", v); end
        n_tests++;
        if (fault[1] !== 1'b1) begin
            n_fail++; $display("FAIL oor_fault_sticky: got %b expected 1", fault[1]);
        end
        rst[1] = 1'b1; @(posedge clk); #1; rst[1] = 1'b0;
        n_tests++;
        if (fault[1] !== 1'b0) begin
            n_fail++; $display("FAIL oor_fault_clear: got %b expected 0", fault[1]);
        end
    endtask

    task automatic test_reset_mid_write();
        int st; logic [31:0] v;
        access(2, 1'b0, 1'b1, 32'h20, 4'hF, 32'h5555AAAA, st, v); idle(2);
        access(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, st, v); idle(2);
        n_tests++;
        if (st !== 4) begin n_fail++; $display("FAIL lat4_read_stall: got %0d expected 4", st); end
        rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h20; be[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        n_tests++;
        if (rdata[2] !== 32'd0) begin
            n_fail++; $display("FAIL midrst_rdata: got %h expected 0", rdata[2]);
        end
        access(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, st, v); idle(2);
        n_tests++;
        if (st !== 4) begin n_fail++; $display("FAIL midrst_restall: got %0d expected 4", st); end
        n_tests++;
        if (v !== 32'h5555AAAA) begin
            n_fail++; $display("FAIL midrst_no_commit: got %h expected 5555aaaa", v);
        end
    endtask

    task automatic test_protocol_drop();
        int st; logic [31:0] v;
        access(2, 1'b0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, st, v); idle(2);
        rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h30; be[2] = 4'hF; wdata[2] = 32'h77;
        @(posedge clk); #1;
        idle(2);
        access(2, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, st, v); idle(2);
        n_tests++;
        if (st !== 4) begin n_fail++; $display("FAIL drop_restall: got %0d expected 4", st); end
        n_tests++;
        if (v !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL drop_no_write: got %h expected 0badf00d", v);
        end
    endtask

    task automatic test_read_write_both();
        int st; logic [31:0] v;
        access(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h00000001, st, v); idle(0);
        n_tests++;
        if (rdata[0] !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL both_rdata_kept: got %h expected aa22cc44", rdata[0]);
        end
        n_tests++;
        if (fault[0] !== 1'b0) begin
            n_fail++; $display("FAIL both_no_fault: got %b expected 0", fault[0]);
        end
        access(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, st, v); idle(0);
        n_tests++;
        if (v !== 32'h00000001) begin
            n_fail++; $display("FAIL both_written: got %h expected 00000001", v);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; be[d] = '0; wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        test_read_lat2();
        test_partial_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_protocol_drop();
        test_read_write_both();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
